adc_capture_scheduler: RTL and testbench

- Sequences the serial ADC reader and frames its 12-bit samples into an AXI-Stream packet stream.
- Issues single-cycle conversion requests at a programmable period, in free-run or triggered mode.
- Limits requests to one conversion in flight and to available FIFO space, so a sample is never dropped.
- Buffers samples in a small FIFO and marks TLAST on the final sample of each frame. Sits between the ADC reader instance and the downstream DMA/stream consumer.

---
 rtl/adc_capture_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_adc_capture_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_scheduler
//  Description : Paces conversion requests to a serial ADC reader (free-run or
//                triggered frames), keeps at most one conversion in flight,
//                never requests more than the sample FIFO can hold, and frames
//                the returned samples as an AXI-Stream packet stream with
//                TLAST on the final sample of each frame.
//  Ports       : i_Clk/i_Rst_n        clock, async active-low reset
//                i_Enable             run capture (level)
//                i_Trigger_Mode       0 free-run, 1 frame waits for i_Trigger
//                i_Trigger            frame-start pulse (honoured in ARMED)
//                i_Period             request interval minus 1
//                i_Frame_Len          samples per frame (0 treated as 1)
//                i_Clear_Counts       clear o_Missed_Count
//                o_ADC_Req            one-cycle conversion request
//                i_ADC_Valid/Data     sample return from the ADC reader
//                o_Axis_*/i_Axis_Ready AXI-Stream master (TDATA zero-extended)
//                o_Busy               state != IDLE
//                o_Missed_Count       saturating count of suppressed requests
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_scheduler #(
   parameter int DATA_WIDTH   = 12,
   parameter int PERIOD_WIDTH = 16,
   parameter int FRAME_WIDTH  = 16,
   parameter int FIFO_DEPTH   = 4    // power of 2, at least 2
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_n,
   input  logic                    i_Enable,
   input  logic                    i_Trigger_Mode,
   input  logic                    i_Trigger,
   input  logic [PERIOD_WIDTH-1:0] i_Period,
   input  logic [FRAME_WIDTH-1:0]  i_Frame_Len,
   input  logic                    i_Clear_Counts,
   output logic                    o_ADC_Req,
   input  logic                    i_ADC_Valid,
   input  logic [DATA_WIDTH-1:0]   i_ADC_Data,
   output logic [15:0]             o_Axis_Data,
   output logic                    o_Axis_Valid,
   output logic                    o_Axis_Last,
   input  logic                    i_Axis_Ready,
   output logic                    o_Busy,
   output logic [15:0]             o_Missed_Count
);

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_ARMED   = 2'd1;
   localparam logic [1:0] c_CAPTURE = 2'd2;
   localparam logic [1:0] c_DRAIN   = 2'd3;

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;

   localparam logic [FRAME_WIDTH-1:0]  c_ONE_F   = 1;
   localparam logic [PERIOD_WIDTH-1:0] c_ONE_P   = 1;
   localparam logic [c_AW-1:0]         c_ONE_PTR = 1;
   localparam logic [c_CW-1:0]         c_ONE_CNT = 1;

   logic [1:0]              r_state;
   logic [1:0]              w_next_state;

   // Frame configuration, frozen for the duration of a frame
   logic [PERIOD_WIDTH-1:0] r_period;
   logic [FRAME_WIDTH-1:0]  r_frame_len;
   logic                    r_mode;

   logic [PERIOD_WIDTH-1:0] r_per_cnt;
   logic [FRAME_WIDTH-1:0]  r_req_cnt;
   logic [FRAME_WIDTH-1:0]  r_smp_cnt;
   logic                    r_outstanding;
   logic                    r_adc_req;
   logic [15:0]             r_missed;

   logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]         r_wr_ptr;
   logic [c_AW-1:0]         r_rd_ptr;
   logic [c_CW-1:0]         r_fifo_cnt;

   logic                    w_active;
   logic                    w_req_left;
   logic                    w_tick;
   logic                    w_space;
   logic                    w_issue;
   logic                    w_miss;
   logic                    w_push;
   logic                    w_last;
   logic                    w_frame_done;
   logic                    w_pop;
   logic                    w_start;
   logic [DATA_WIDTH:0]     w_head;

   assign w_active   = (r_state == c_CAPTURE) || (r_state == c_DRAIN);
   assign w_req_left = r_req_cnt < r_frame_len;
   assign w_tick     = w_active && w_req_left && (r_per_cnt == r_period);

   // Space is reserved for the in-flight sample so a push can never overflow
   assign w_space    = (32'(r_fifo_cnt) + 32'(r_outstanding)) < 32'(FIFO_DEPTH);
   assign w_issue    = w_tick && !r_outstanding && w_space;
   assign w_miss     = w_tick && !w_issue;

   assign w_push       = i_ADC_Valid && r_outstanding;
   assign w_last       = (r_smp_cnt == (r_frame_len - c_ONE_F));
   assign w_frame_done = w_push && w_last;

   assign o_Axis_Valid = (r_fifo_cnt != '0);
   assign w_pop        = o_Axis_Valid && i_Axis_Ready;

   // A new frame begins on any entry into CAPTURE, including the back-to-back
   // restart in free-run mode
   assign w_start = (w_next_state == c_CAPTURE) &&
                    ((r_state != c_CAPTURE) || w_frame_done);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (i_Enable) begin
               w_next_state = i_Trigger_Mode ? c_ARMED : c_CAPTURE;
            end
         end
         c_ARMED: begin
            if (!i_Enable) begin
               w_next_state = c_IDLE;
            end else if (i_Trigger) begin
               w_next_state = c_CAPTURE;
            end
         end
         c_CAPTURE: begin
            if (w_frame_done) begin
               if (!i_Enable) begin
                  w_next_state = c_IDLE;
               end else if (r_mode) begin
                  w_next_state = c_ARMED;
               end else begin
                  w_next_state = c_CAPTURE;
               end
            end else if (!i_Enable) begin
               w_next_state = c_DRAIN;
            end
         end
         c_DRAIN: begin
            if (w_frame_done) begin
               w_next_state = c_IDLE;
            end
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      o_Busy = (r_state != c_IDLE);
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_period      <= '0;
         r_frame_len   <= '0;
         r_mode        <= 1'b0;
         r_per_cnt     <= '0;
         r_req_cnt     <= '0;
         r_smp_cnt     <= '0;
         r_outstanding <= 1'b0;
         r_adc_req     <= 1'b0;
         r_missed      <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_fifo_cnt    <= '0;
      end else begin
         if (w_start) begin
            r_period    <= i_Period;
            r_frame_len <= (i_Frame_Len == '0) ? c_ONE_F : i_Frame_Len;
            r_mode      <= i_Trigger_Mode;
            r_per_cnt   <= '0;
            r_req_cnt   <= '0;
            r_smp_cnt   <= '0;
         end else begin
            // Counter only runs while the frame still owes requests
            if (w_tick) begin
               r_per_cnt <= '0;
            end else if (w_active && w_req_left) begin
               r_per_cnt <= r_per_cnt + c_ONE_P;
            end
            if (w_issue) begin
               r_req_cnt <= r_req_cnt + c_ONE_F;
            end
            if (w_push) begin
               r_smp_cnt <= r_smp_cnt + c_ONE_F;
            end
         end

         r_adc_req <= w_issue;

         // Issue requires outstanding=0 and push requires outstanding=1,
         // so the two never coincide
         if (w_issue) begin
            r_outstanding <= 1'b1;
         end else if (w_push) begin
            r_outstanding <= 1'b0;
         end

         if (i_Clear_Counts) begin
            r_missed <= '0;
         end else if (w_miss && (r_missed != 16'hFFFF)) begin
            r_missed <= r_missed + 16'd1;
         end

         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + c_ONE_CNT;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - c_ONE_CNT;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Storage array carries no reset; the head is masked until an entry exists
   always_ff @(posedge i_Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_last, i_ADC_Data};
      end
   end

   assign w_head         = r_mem[r_rd_ptr];
   assign o_Axis_Data    = o_Axis_Valid ? 16'(w_head[DATA_WIDTH-1:0]) : 16'h0000;
   assign o_Axis_Last    = o_Axis_Valid & w_head[DATA_WIDTH];
   assign o_ADC_Req      = r_adc_req;
   assign o_Missed_Count = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture_scheduler
//  Description : Directed self-checking bench for adc_capture_scheduler with a
//                responding ADC reader model (sample 3 clocks after request).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        trig_mode;
   logic        trigger;
   logic [15:0] period;
   logic [15:0] frame_len;
   logic        clear_counts;
   logic        adc_req;
   logic        adc_valid;
   logic [11:0] adc_data;
   logic [15:0] axis_data;
   logic        axis_valid;
   logic        axis_last;
   logic        axis_ready;
   logic        busy;
   logic [15:0] missed;

   // ADC model and spurious-valid injector share the reader interface
   logic        m_valid;
   logic [11:0] m_data;
   int          pend;
   int          m_cnt;
   logic        s_valid;
   logic [11:0] s_data;

   assign adc_valid = m_valid | s_valid;
   assign adc_data  = s_valid ? s_data : m_data;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          base;
   int          m1;
   int          k;
   int          req_q[$];
   logic [16:0] beat_q[$];

   adc_capture_scheduler #(
      .DATA_WIDTH  (12),
      .PERIOD_WIDTH(16),
      .FRAME_WIDTH (16),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .i_Enable      (enable),
      .i_Trigger_Mode(trig_mode),
      .i_Trigger     (trigger),
      .i_Period      (period),
      .i_Frame_Len   (frame_len),
      .i_Clear_Counts(clear_counts),
      .o_ADC_Req     (adc_req),
      .i_ADC_Valid   (adc_valid),
      .i_ADC_Data    (adc_data),
      .o_Axis_Data   (axis_data),
      .o_Axis_Valid  (axis_valid),
      .o_Axis_Last   (axis_last),
      .i_Axis_Ready  (axis_ready),
      .o_Busy        (busy),
      .o_Missed_Count(missed)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ADC reader model: valid with data 0xA00+n three clocks after each request
   initial begin
      m_valid = 1'b0;
      m_data  = '0;
      pend    = 0;
      m_cnt   = 0;
      forever begin
         @(negedge clk);
         m_valid = 1'b0;
         if (!rst_n) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  m_valid = 1'b1;
                  m_data  = 12'hA00 + 12'(m_cnt);
                  m_cnt++;
               end
            end
            if (adc_req) pend = 3;
         end
      end
   end

   // Logs of requests (cycle stamp) and accepted beats ({last, data})
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && adc_req) req_q.push_back(cyc);
         if (rst_n && axis_valid && axis_ready) beat_q.push_back({axis_last, axis_data});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int n, input int bound, input string tag);
      int j = 0;
      while ((beat_q.size() < n) && (j < bound)) begin
         step(1);
         j++;
      end
      chk(tag, 32'(beat_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int bound, input string tag);
      int j = 0;
      while (busy && (j < bound)) begin
         step(1);
         j++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic clear_logs();
      req_q.delete();
      beat_q.delete();
      base = m_cnt;
   endtask

   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      trig_mode    = 1'b0;
      trigger      = 1'b0;
      period       = 16'd0;
      frame_len    = 16'd0;
      clear_counts = 1'b0;
      axis_ready   = 1'b1;
      s_valid      = 1'b0;
      s_data       = '0;

      // ---- reset state
      step(3);
      chk("rst_req",    32'(adc_req),    32'd0);
      chk("rst_valid",  32'(axis_valid), 32'd0);
      chk("rst_last",   32'(axis_last),  32'd0);
      chk("rst_data",   32'(axis_data),  32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_missed", 32'(missed),     32'd0);
      rst_n = 1'b1;
      step(2);

      // ---- free-run: period 9, frame 4
      clear_logs();
      trig_mode = 1'b0;
      period    = 16'd9;
      frame_len = 16'd4;
      enable    = 1'b1;
      wait_beats(8, 300, "fr_timeout");
      chk("fr_gap01", 32'(req_q[1] - req_q[0]), 32'd10);
      chk("fr_gap12", 32'(req_q[2] - req_q[1]), 32'd10);
      chk("fr_gap67", 32'(req_q[7] - req_q[6]), 32'd10);
      for (int i = 0; i < 8; i++) begin
         chk("fr_data", 32'(beat_q[i][15:0]), 32'(16'h0A00 + 16'(base + i)));
         chk("fr_last", 32'(beat_q[i][16]), 32'((i % 4) == 3));
      end
      chk("fr_missed", 32'(missed), 32'd0);
      enable = 1'b0;
      wait_idle(300, "fr_idle");
      step(3);

      // ---- triggered: trigger with the IDLE->ARMED step is ignored
      clear_logs();
      trig_mode = 1'b1;
      period    = 16'd2;
      frame_len = 16'd3;
      enable    = 1'b1;
      trigger   = 1'b1;
      step(1);
      trigger   = 1'b0;
      step(20);
      chk("tr_armed_busy", 32'(busy), 32'd1);
      chk("tr_no_req", 32'(req_q.size()), 32'd0);
      trigger = 1'b1;
      step(1);
      trigger = 1'b0;
      wait_beats(1, 100, "tr_first_timeout");
      trigger = 1'b1;
      step(1);
      trigger = 1'b0;
      wait_beats(3, 100, "tr_timeout");
      step(30);
      chk("tr_req_cnt",  32'(req_q.size()),  32'd3);
      chk("tr_beat_cnt", 32'(beat_q.size()), 32'd3);
      chk("tr_last0", 32'(beat_q[0][16]), 32'd0);
      chk("tr_last1", 32'(beat_q[1][16]), 32'd0);
      chk("tr_last2", 32'(beat_q[2][16]), 32'd1);
      chk("tr_data2", 32'(beat_q[2][15:0]), 32'(16'h0A00 + 16'(base + 2)));
      chk("tr_rearmed", 32'(busy), 32'd1);
      enable = 1'b0;
      step(2);
      chk("tr_disarm", 32'(busy), 32'd0);

      // ---- backpressure: period 0, frame 8, ready low
      clear_logs();
      trig_mode  = 1'b0;
      period     = 16'd0;
      frame_len  = 16'd8;
      axis_ready = 1'b0;
      enable     = 1'b1;
      step(40);
      chk("bp_req_cnt", 32'(req_q.size()), 32'd4);
      chk("bp_valid", 32'(axis_valid), 32'd1);
      chk("bp_head",  32'(axis_data), 32'(16'h0A00 + 16'(base)));
      chk("bp_last",  32'(axis_last), 32'd0);
      m1 = int'(missed);
      step(10);
      chk("bp_miss_rate", 32'(missed), 32'(m1 + 10));
      chk("bp_hold", 32'(axis_data), 32'(16'h0A00 + 16'(base)));
      axis_ready = 1'b1;
      enable     = 1'b0;
      wait_idle(300, "bp_idle");
      step(3);
      chk("bp_beat_cnt", 32'(beat_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("bp_data", 32'(beat_q[i][15:0]), 32'(16'h0A00 + 16'(base + i)));
         chk("bp_lastbit", 32'(beat_q[i][16]), 32'(i == 7));
      end

      // ---- clear, then disable mid-frame (frame 8, drop after 3 samples)
      clear_counts = 1'b1;
      step(1);
      clear_counts = 1'b0;
      chk("clr_missed", 32'(missed), 32'd0);
      clear_logs();
      period    = 16'd4;
      frame_len = 16'd8;
      enable    = 1'b1;
      wait_beats(3, 200, "dis_timeout");
      enable = 1'b0;
      wait_idle(300, "dis_idle");
      step(20);
      chk("dis_beat_cnt", 32'(beat_q.size()), 32'd8);
      chk("dis_req_cnt",  32'(req_q.size()),  32'd8);
      chk("dis_last6", 32'(beat_q[6][16]), 32'd0);
      chk("dis_last7", 32'(beat_q[7][16]), 32'd1);
      chk("dis_data7", 32'(beat_q[7][15:0]), 32'(16'h0A00 + 16'(base + 7)));
      chk("dis_busy", 32'(busy), 32'd0);
      chk("dis_missed", 32'(missed), 32'd0);

      // ---- frame length 0 behaves as 1
      clear_logs();
      frame_len = 16'd0;
      enable    = 1'b1;
      wait_beats(3, 200, "fl0_timeout");
      chk("fl0_last0", 32'(beat_q[0][16]), 32'd1);
      chk("fl0_last1", 32'(beat_q[1][16]), 32'd1);
      chk("fl0_last2", 32'(beat_q[2][16]), 32'd1);
      enable = 1'b0;
      wait_idle(200, "fl0_idle");
      step(3);

      // ---- spurious ADC valid with nothing outstanding
      clear_logs();
      period    = 16'd50;
      frame_len = 16'd2;
      enable    = 1'b1;
      step(5);
      s_data  = 12'h123;
      s_valid = 1'b1;
      step(1);
      s_valid = 1'b0;
      step(3);
      chk("spur_valid", 32'(axis_valid), 32'd0);
      chk("spur_beats", 32'(beat_q.size()), 32'd0);
      enable = 1'b0;
      wait_idle(400, "spur_idle");
      step(3);

      // ---- missed-count saturation, clear vs increment, async reset
      clear_counts = 1'b1;
      step(1);
      clear_counts = 1'b0;
      clear_logs();
      period     = 16'd0;
      frame_len  = 16'd100;
      axis_ready = 1'b0;
      enable     = 1'b1;
      k = 0;
      while ((missed != 16'hFFFF) && (k < 70000)) begin
         step(1);
         k++;
      end
      chk("sat_reach", 32'(missed), 32'h0000FFFF);
      step(5);
      chk("sat_hold", 32'(missed), 32'h0000FFFF);
      clear_counts = 1'b1;
      step(1);
      clear_counts = 1'b0;
      chk("clr_prio", 32'(missed), 32'd0);
      step(1);
      chk("clr_resume", 32'(missed), 32'd1);
      chk("full_valid", 32'(axis_valid), 32'd1);
      #2;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      chk("arst_req",    32'(adc_req),    32'd0);
      chk("arst_valid",  32'(axis_valid), 32'd0);
      chk("arst_last",   32'(axis_last),  32'd0);
      chk("arst_data",   32'(axis_data),  32'd0);
      chk("arst_busy",   32'(busy),       32'd0);
      chk("arst_missed", 32'(missed),     32'd0);
      step(3);
      rst_n = 1'b1;
      step(2);
      clear_logs();
      axis_ready = 1'b1;
      period     = 16'd2;
      frame_len  = 16'd2;
      enable     = 1'b1;
      wait_beats(2, 100, "rst_restart_timeout");
      enable = 1'b0;
      chk("rr_data0", 32'(beat_q[0][15:0]), 32'(16'h0A00 + 16'(base)));
      chk("rr_last0", 32'(beat_q[0][16]), 32'd0);
      chk("rr_data1", 32'(beat_q[1][15:0]), 32'(16'h0A00 + 16'(base + 1)));
      chk("rr_last1", 32'(beat_q[1][16]), 32'd1);
      wait_idle(200, "rr_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
